sid_mixer_pwm: RTL and testbench
================================

SID_MIXER_PWM -- requirements
Module: sid_mixer_pwm

Interface
REQ-001 Parameter: ENABLE_SAT, default 1, selects saturating gain stage (1) or fixed attenuating gain stage (0).
REQ-002 clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 voice0  input  8  unsigned amplitude of voice 0, from voice stage output.
REQ-005 voice1  input  8  unsigned amplitude of voice 1.
REQ-006 voice2  input  8  unsigned amplitude of voice 2.
REQ-007 voice_mute  input  3  per-voice mute, bit n forces voice n to 0 in the sum.
REQ-008 volume  input  4  master volume, 0 = silent, 15 = maximum.
REQ-009 level  output  8  current mixed sample (gain-stage register), for debug/readback.
REQ-010 duty  output  8  PWM duty value latched for the current PWM period.
REQ-011 sample_stb  output  1  one-cycle pulse marking start of each PWM period.
REQ-012 pwm_out  output  1  registered 1-bit PWM audio output.

Function
REQ-013 Stage 1 SHALL register, every cycle: sum_r[9:0] = masked voice0 + masked voice1 + masked voice2, zero-extended, no overflow (max 765).
REQ-014 Stage 2 SHALL register, every cycle: prod = sum_r * volume (14 bits, max 11475).
REQ-015 With ENABLE_SAT=1, level SHALL be 8'hFF when prod[13:12] != 0, otherwise prod[11:4].
REQ-016 With ENABLE_SAT=0, level SHALL be prod[13:6] (never clips).
REQ-017 Input-to-level latency SHALL be exactly 2 clocks: voice/volume/mute change sampled at edge k appears on level after edge k+1.
REQ-018 An 8-bit period counter pwm_cnt SHALL increment by 1 every cycle and wrap 255 -> 0 (period = 256 clocks).
REQ-019 On the edge where pwm_cnt == 255, duty SHALL load level; duty SHALL be constant for the rest of the period.
REQ-020 sample_stb SHALL be high exactly during cycles where pwm_cnt == 0, i.e. one cycle per 256, coincident with the first cycle of the new duty.
REQ-021 pwm_out SHALL register (pwm_cnt < duty) every cycle; high-time per period SHALL equal duty clocks, with pwm_out lagging pwm_cnt by one clock.
REQ-022 duty = 0 SHALL give pwm_out constantly 0; duty = 255 SHALL give 255 high and 1 low clock per period.
REQ-023 Level changes mid-period SHALL NOT affect pwm_out until the next wrap (no glitching within a period).
REQ-024 volume = 0 or voice_mute = 3'b111 SHALL yield level = 0 after 2 clocks, duty = 0 after the next wrap.
REQ-025 Mute and volume changes in the same cycle as a wrap SHALL follow REQ-017 latency; the wrap latches the old level register value.

Reset
REQ-026 While rst_n is low at a rising edge: sum_r, level, duty, pwm_cnt SHALL be 0; pwm_out SHALL be 0; sample_stb SHALL be 0.
REQ-027 On the first edge with rst_n high, pwm_cnt SHALL become 1; sample_stb SHALL assert in the cycle after pwm_cnt next wraps to 0, not immediately after reset.
REQ-028 Reset asserted mid-period SHALL abort the period; no partial duty is carried over.

Verification
REQ-029 All voices 8'h40, mute 0, volume 15, SAT=1 -> sum 192, prod 2880, level 8'hB4 after 2 clocks; next period pwm_out high 180 of 256 clocks.
REQ-030 All voices 8'hFF, volume 15, SAT=1 -> prod 11475, level 8'hFF (clipped); SAT=0 build -> level 8'hB3.
REQ-031 voice0=8'hFF, others 0, mute=3'b001, volume 15 -> level 0; clear mute -> level 8'hEF two clocks later.
REQ-032 Change voices at pwm_cnt=100 -> duty and pwm_out pattern unchanged until wrap; sample_stb pulses once per 256 clocks, duty updates with it.
REQ-033 volume 0 with full-scale voices -> pwm_out stays 0 for entire period after next wrap; volume 15, voices giving level 255 -> exactly one low clock per period.
REQ-034 Assert rst_n low at pwm_cnt=77 for 3 clocks -> all outputs 0, counter restarts from 0, first sample_stb 256 clocks after release.

Source files
------------

// File: rtl/sid_mixer_pwm.sv
// Three-voice mixer with master volume and a gain stage, driving a 256-clock PWM DAC.
// Duty is latched once per period, so level changes never glitch a period in progress.
module sid_mixer_pwm #(
  parameter int unsigned ENABLE_SAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] voice0,
  input  logic [7:0] voice1,
  input  logic [7:0] voice2,
  input  logic [2:0] voice_mute,
  input  logic [3:0] volume,
  output logic [7:0] level,
  output logic [7:0] duty,
  output logic       sample_stb,
  output logic       pwm_out
);

  logic [7:0]  w_v0, w_v1, w_v2;
  logic [9:0]  w_sum;
  logic [13:0] w_prod;
  logic [7:0]  w_gain;

  logic [9:0]  r_sum;
  logic [3:0]  r_vol;
  logic [7:0]  r_level;
  logic [7:0]  r_duty;
  logic [7:0]  r_cnt;
  logic        r_stb;
  logic        r_pwm;

  always_comb begin
    w_v0  = voice_mute[0] ? 8'd0 : voice0;
    w_v1  = voice_mute[1] ? 8'd0 : voice1;
    w_v2  = voice_mute[2] ? 8'd0 : voice2;
    w_sum = {2'b00, w_v0} + {2'b00, w_v1} + {2'b00, w_v2};
  end

  // Volume is registered alongside the sum so it shares the 2-clock input-to-level latency.
  assign w_prod = {4'd0, r_sum} * {10'd0, r_vol};

  always_comb begin
    w_gain = w_prod[13:6];
    if (ENABLE_SAT != 0) begin
      w_gain = (w_prod[13:12] != 2'b00) ? 8'hFF : w_prod[11:4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_vol   <= '0;
      r_level <= '0;
      r_duty  <= '0;
      r_cnt   <= '0;
      r_stb   <= 1'b0;
      r_pwm   <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_vol   <= volume;
      r_level <= w_gain;
      r_cnt   <= r_cnt + 8'd1;
      // Strobe is registered from cnt==255 so it is low right after reset while cnt is 0.
      r_stb   <= (r_cnt == 8'hFF);
      if (r_cnt == 8'hFF) begin
        r_duty <= r_level;
      end
      r_pwm   <= (r_cnt < r_duty);
    end
  end

  assign level      = r_level;
  assign duty       = r_duty;
  assign sample_stb = r_stb;
  assign pwm_out    = r_pwm;

endmodule

// File: tb/tb_sid_mixer_pwm.sv
// Directed bench for sid_mixer_pwm: saturating and attenuating builds driven from shared inputs.
module tb_sid_mixer_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] voice0, voice1, voice2;
  logic [2:0] voice_mute;
  logic [3:0] volume;

  logic [7:0] level1, duty1, level0, duty0;
  logic       stb1, pwm1, stb0, pwm0;

  int vectors = 0;
  int errors  = 0;
  int tpos    = 0;
  int hi1, hi0, stbs;
  int a1, a0, as;

  always #5 clk = ~clk;

  sid_mixer_pwm #(.ENABLE_SAT(1)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .voice0     (voice0),
    .voice1     (voice1),
    .voice2     (voice2),
    .voice_mute (voice_mute),
    .volume     (volume),
    .level      (level1),
    .duty       (duty1),
    .sample_stb (stb1),
    .pwm_out    (pwm1)
  );

  sid_mixer_pwm #(.ENABLE_SAT(0)) u_att (
    .clk        (clk),
    .rst_n      (rst_n),
    .voice0     (voice0),
    .voice1     (voice1),
    .voice2     (voice2),
    .voice_mute (voice_mute),
    .volume     (volume),
    .level      (level0),
    .duty       (duty0),
    .sample_stb (stb0),
    .pwm_out    (pwm0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each edge and tallying outputs.
  task automatic run(input int n, output int h1, output int h0, output int s);
    h1 = 0; h0 = 0; s = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tpos = rst_n ? (tpos + 1) % 256 : 0;
      h1 += int'(pwm1);
      h0 += int'(pwm0);
      s  += int'(stb1);
      if (stb0 !== stb1) begin
        check("stb_sync", int'(stb0), int'(stb1));
      end
    end
  endtask

  task automatic set_voices(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    voice0 = a; voice1 = b; voice2 = c;
  endtask

  initial begin
    rst_n = 1'b0;
    set_voices(8'h00, 8'h00, 8'h00);
    voice_mute = 3'b000;
    volume = 4'd0;
    run(3, hi1, hi0, stbs);
    check("rst_level", int'(level1), 0);
    check("rst_duty", int'(duty1), 0);
    check("rst_stb", int'(stb1), 0);
    check("rst_pwm", int'(pwm1), 0);

    // 0x40 x3 at volume 15: sum 192, prod 2880
    set_voices(8'h40, 8'h40, 8'h40);
    volume = 4'd15;
    rst_n = 1'b1;
    run(1, hi1, hi0, stbs);
    check("lat1_level", int'(level1), 0);
    check("post_rst_stb", int'(stb1), 0);
    run(1, hi1, hi0, stbs);
    check("lat2_level_sat", int'(level1), 8'hB4);
    check("lat2_level_att", int'(level0), 8'h2D);

    run(254, hi1, hi0, stbs);
    check("first_stb_count", stbs, 1);
    check("first_stb_now", int'(stb1), 1);
    check("first_period_hi", hi1, 0);
    check("duty_b4", int'(duty1), 8'hB4);

    run(256, hi1, hi0, stbs);
    check("period_hi_180", hi1, 180);
    check("period_hi_att", hi0, 45);
    check("period_stbs", stbs, 1);

    // Mid-period change at pwm_cnt=100 must not alter the running period
    run(100, a1, a0, as);
    set_voices(8'hFF, 8'hFF, 8'hFF);
    run(2, hi1, hi0, stbs);
    check("clip_level_sat", int'(level1), 8'hFF);
    check("clip_level_att", int'(level0), 8'hB3);
    check("mid_duty_hold", int'(duty1), 8'hB4);
    a1 += hi1; a0 += hi0; as += stbs;
    run(154, hi1, hi0, stbs);
    a1 += hi1; a0 += hi0; as += stbs;
    check("mid_change_hi", a1, 180);
    check("mid_change_hi_att", a0, 45);
    check("mid_change_stbs", as, 1);
    check("wrap_duty_sat", int'(duty1), 8'hFF);
    check("wrap_duty_att", int'(duty0), 8'hB3);

    // Volume 0 takes effect on level after 2 clocks, on pwm only after the wrap
    volume = 4'd0;
    run(2, a1, a0, as);
    check("vol0_level", int'(level1), 0);
    check("vol0_level_att", int'(level0), 0);
    run(254, hi1, hi0, stbs);
    a1 += hi1; a0 += hi0;
    check("full_hi_255", a1, 255);
    check("full_hi_att", a0, 179);
    check("vol0_duty", int'(duty1), 0);
    run(256, hi1, hi0, stbs);
    check("silent_hi", hi1, 0);
    check("silent_hi_att", hi0, 0);

    volume = 4'd15;
    set_voices(8'hFF, 8'h00, 8'h00);
    voice_mute = 3'b001;
    run(2, hi1, hi0, stbs);
    check("mute0_level", int'(level1), 0);
    voice_mute = 3'b000;
    run(1, hi1, hi0, stbs);
    check("unmute_lat1", int'(level1), 0);
    run(1, hi1, hi0, stbs);
    check("unmute_level_sat", int'(level1), 8'hEF);
    check("unmute_level_att", int'(level0), 8'h3B);
    set_voices(8'hFF, 8'hFF, 8'hFF);
    voice_mute = 3'b111;
    run(2, hi1, hi0, stbs);
    check("mute_all_level", int'(level1), 0);

    // Reset at pwm_cnt=77 for 3 clocks
    voice_mute = 3'b000;
    set_voices(8'h40, 8'h40, 8'h40);
    run((77 - tpos + 256) % 256, hi1, hi0, stbs);
    rst_n = 1'b0;
    run(3, hi1, hi0, stbs);
    check("mid_rst_level", int'(level1), 0);
    check("mid_rst_duty", int'(duty1), 0);
    check("mid_rst_stb", int'(stb1), 0);
    check("mid_rst_pwm", int'(pwm1), 0);
    rst_n = 1'b1;
    run(255, hi1, hi0, stbs);
    check("rel_no_stb", stbs, 0);
    check("rel_hi", hi1, 0);
    check("rel_duty", int'(duty1), 0);
    run(1, hi1, hi0, stbs);
    check("rel_stb_256", int'(stb1), 1);
    check("rel_duty_load", int'(duty1), 8'hB4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
